// File: rtl/evt_packetizer_pkg.sv
// evt_packetizer_pkg
// Shared definitions for the event packetizer. It holds the packet width, the
// field offsets and widths of a short multicast packet, the index of the
// parity bit, and the helpers that build a packet from a routing key.
package evt_packetizer_pkg;

  // Short multicast packet layout: [0] parity, [7:1] header, [39:8] key,
  // [71:40] payload.
  localparam int PKT_BITS = 72;
  localparam int PAR_IDX  = 0;
  localparam int HDR_LSB  = 1;
  localparam int HDR_W    = 7;
  localparam int KEY_LSB  = 8;
  localparam int KEY_W    = 32;
  localparam int PLD_LSB  = 40;
  localparam int PLD_W    = 32;

  // Parity bit value that makes the total count of ones in the packet odd.
  // The parity position of the argument must already hold zero.
  function automatic logic odd_parity(input logic [PKT_BITS-1:0] pkt);
    odd_parity = ~(^pkt);
  endfunction

  // Build a multicast, short, payload-free packet that carries 'key'.
  function automatic logic [PKT_BITS-1:0] build_pkt(input logic [KEY_W-1:0] key);
    logic [PKT_BITS-1:0] pkt;
    pkt                    = '0;
    pkt[HDR_LSB +: HDR_W]  = 7'b000_0000;
    pkt[PLD_LSB +: PLD_W]  = 32'h0000_0000;
    pkt[KEY_LSB +: KEY_W]  = key;
    pkt[PAR_IDX]           = odd_parity(pkt);
    build_pkt              = pkt;
  endfunction

endpackage

// File: rtl/evt_packetizer.sv
// evt_packetizer
// Turns a 32-bit peripheral event stream into SpiNNaker multicast packets.
// Full-word events become one packet whose key is
// key_base_in | (evt_data_in & key_mask_in); partial-word events are
// discarded. A packet stalled downstream for drop_wait_in cycles is dropped
// (0 disables dropping). Every discard or drop gives a one-cycle pulse on
// in_drp_cnt_out, and accepted beats flagged last are counted in frm_cnt_out.
//
// Ports
//   clk, reset           : clock (rising edge), async active-high reset
//   evt_*                : input event stream (valid/ready handshake)
//   key_base_in/mask_in  : routing key construction
//   drop_wait_in         : stall cycles before a held packet is dropped
//   pkt_*                : packet stream towards the packet transmitter
//   in_drp_cnt_out       : pulse per discarded event or dropped packet
//   frm_cnt_out          : number of accepted beats with evt_last_in set
module evt_packetizer
  import evt_packetizer_pkg::*;
#(
  parameter int DROP_BITS    = 16,
  parameter int FRM_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             evt_data_in,
  input  logic [3:0]              evt_keep_in,
  input  logic                    evt_last_in,
  input  logic                    evt_vld_in,
  output logic                    evt_rdy_out,
  input  logic [31:0]             key_base_in,
  input  logic [31:0]             key_mask_in,
  input  logic [DROP_BITS-1:0]    drop_wait_in,
  output logic [PKT_BITS-1:0]     pkt_data_out,
  output logic                    pkt_vld_out,
  input  logic                    pkt_rdy_in,
  output logic                    in_drp_cnt_out,
  output logic [FRM_CNT_BITS-1:0] frm_cnt_out
);

  localparam logic [DROP_BITS-1:0]    DROP_ONE = DROP_BITS'(1);
  localparam logic [FRM_CNT_BITS-1:0] FRM_ONE  = FRM_CNT_BITS'(1);

  logic [PKT_BITS-1:0]     pkt_data_q, pkt_data_d;
  logic                    pkt_vld_q, pkt_vld_d;
  logic [DROP_BITS-1:0]    stall_cnt_q, stall_cnt_d;
  logic                    drp_q, drp_d;
  logic [FRM_CNT_BITS-1:0] frm_cnt_q, frm_cnt_d;

  logic stalled_s;
  logic drop_now_s;
  logic accept_s;
  logic load_s;
  logic discard_s;

  // Handshake decode and stall-timeout detection.
  always_comb begin
    stalled_s  = pkt_vld_q && !pkt_rdy_in;
    // drop_wait_in is re-read every cycle, so a change mid-stall applies to
    // the very next compare.
    drop_now_s = (drop_wait_in != '0) && stalled_s &&
                 (stall_cnt_q == (drop_wait_in - DROP_ONE));
    // A drop frees the output register in the same cycle, so a new event
    // can be taken while the held packet is thrown away.
    evt_rdy_out = !pkt_vld_q || pkt_rdy_in || drop_now_s;
    accept_s    = evt_vld_in && evt_rdy_out;
    load_s      = accept_s && (evt_keep_in == 4'b1111);
    discard_s   = accept_s && (evt_keep_in != 4'b1111);
  end

  // Next state of the output register, stall timer, drop pulse and frame count.
  always_comb begin
    pkt_data_d  = pkt_data_q;
    pkt_vld_d   = pkt_vld_q;
    stall_cnt_d = stall_cnt_q;
    drp_d       = 1'b0;
    frm_cnt_d   = frm_cnt_q;

    if (load_s) begin
      pkt_data_d = build_pkt(key_base_in | (evt_data_in & key_mask_in));
      pkt_vld_d  = 1'b1;
    end else if (pkt_rdy_in || drop_now_s) begin
      pkt_vld_d  = 1'b0;
    end else begin
      pkt_vld_d  = pkt_vld_q;
    end

    if (load_s) begin
      stall_cnt_d = '0;
    end else if (stalled_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + DROP_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    // A discard and a drop landing together still give a single pulse.
    if (discard_s || drop_now_s) begin
      drp_d = 1'b1;
    end else begin
      drp_d = 1'b0;
    end

    // Discarded beats still mark frame boundaries.
    if (accept_s && evt_last_in) begin
      frm_cnt_d = frm_cnt_q + FRM_ONE;
    end else begin
      frm_cnt_d = frm_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_data_q  <= '0;
      pkt_vld_q   <= 1'b0;
      stall_cnt_q <= '0;
      drp_q       <= 1'b0;
      frm_cnt_q   <= '0;
    end else begin
      pkt_data_q  <= pkt_data_d;
      pkt_vld_q   <= pkt_vld_d;
      stall_cnt_q <= stall_cnt_d;
      drp_q       <= drp_d;
      frm_cnt_q   <= frm_cnt_d;
    end
  end

  assign pkt_data_out   = pkt_data_q;
  assign pkt_vld_out    = pkt_vld_q;
  assign in_drp_cnt_out = drp_q;
  assign frm_cnt_out    = frm_cnt_q;

endmodule

// File: tb/tb_evt_packetizer.sv
// tb_evt_packetizer
// Directed self-checking bench for evt_packetizer.
module tb_evt_packetizer;

  logic        clk;
  logic        reset;
  logic [31:0] evt_data_in;
  logic [3:0]  evt_keep_in;
  logic        evt_last_in;
  logic        evt_vld_in;
  logic        evt_rdy_out;
  logic [31:0] key_base_in;
  logic [31:0] key_mask_in;
  logic [15:0] drop_wait_in;
  logic [71:0] pkt_data_out;
  logic        pkt_vld_out;
  logic        pkt_rdy_in;
  logic        in_drp_cnt_out;
  logic [15:0] frm_cnt_out;

  int n_checks;
  int n_fails;
  logic [15:0] exp_frm;

  evt_packetizer dut (
    .clk            (clk),
    .reset          (reset),
    .evt_data_in    (evt_data_in),
    .evt_keep_in    (evt_keep_in),
    .evt_last_in    (evt_last_in),
    .evt_vld_in     (evt_vld_in),
    .evt_rdy_out    (evt_rdy_out),
    .key_base_in    (key_base_in),
    .key_mask_in    (key_mask_in),
    .drop_wait_in   (drop_wait_in),
    .pkt_data_out   (pkt_data_out),
    .pkt_vld_out    (pkt_vld_out),
    .pkt_rdy_in     (pkt_rdy_in),
    .in_drp_cnt_out (in_drp_cnt_out),
    .frm_cnt_out    (frm_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected packet: payload 0, key, header 0, odd parity over the whole word.
  function automatic logic [71:0] exp_pkt(input logic [31:0] key);
    exp_pkt = {32'h0000_0000, key, 7'h00, ~(^key)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #23;
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL reset_vld got %0b exp 0", pkt_vld_out); end
    n_checks++;
    if (pkt_data_out !== 72'h0) begin n_fails++; $display("FAIL reset_data got %h exp 0", pkt_data_out); end
    n_checks++;
    if (in_drp_cnt_out !== 1'b0) begin n_fails++; $display("FAIL reset_drp got %0b exp 0", in_drp_cnt_out); end
    n_checks++;
    if (frm_cnt_out !== 16'h0) begin n_fails++; $display("FAIL reset_frm got %0d exp 0", frm_cnt_out); end
    reset = 1'b0;
    step();
    n_checks++;
    if (evt_rdy_out !== 1'b1) begin n_fails++; $display("FAIL reset_rdy got %0b exp 1", evt_rdy_out); end
    exp_frm = 16'h0;
  endtask

  task automatic test_basic();
    key_base_in  = 32'h1234_0000;
    key_mask_in  = 32'h0000_FFFF;
    drop_wait_in = 16'd0;
    pkt_rdy_in   = 1'b1;
    evt_data_in  = 32'hABCD_5678;
    evt_keep_in  = 4'b1111;
    evt_last_in  = 1'b0;
    evt_vld_in   = 1'b1;
    step();
    evt_vld_in = 1'b0;
    n_checks++;
    if (pkt_vld_out !== 1'b1) begin n_fails++; $display("FAIL basic_vld got %0b exp 1", pkt_vld_out); end
    // 0x12345678 has 13 ones, so parity bit is 0.
    n_checks++;
    if (pkt_data_out !== 72'h00_0000_0012_3456_7800) begin
      n_fails++; $display("FAIL basic_data got %h exp %h", pkt_data_out, 72'h00_0000_0012_3456_7800);
    end
    step();
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL basic_vld_off got %0b exp 0", pkt_vld_out); end
    n_checks++;
    if (in_drp_cnt_out !== 1'b0) begin n_fails++; $display("FAIL basic_drp got %0b exp 0", in_drp_cnt_out); end
  endtask

  task automatic test_drop();
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 16'd4;
    key_base_in  = 32'h0000_0000;
    key_mask_in  = 32'hFFFF_FFFF;
    evt_data_in  = 32'h0000_00A5;
    evt_keep_in  = 4'b1111;
    evt_vld_in   = 1'b1;
    step();
    evt_vld_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pkt_vld_out !== 1'b1) begin n_fails++; $display("FAIL drop_hold_vld[%0d] got %0b exp 1", i, pkt_vld_out); end
      n_checks++;
      if (in_drp_cnt_out !== 1'b0) begin n_fails++; $display("FAIL drop_hold_drp[%0d] got %0b exp 0", i, in_drp_cnt_out); end
      n_checks++;
      if (evt_rdy_out !== (i == 3)) begin n_fails++; $display("FAIL drop_rdy[%0d] got %0b exp %0b", i, evt_rdy_out, (i == 3)); end
      step();
    end
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL drop_vld got %0b exp 0", pkt_vld_out); end
    n_checks++;
    if (in_drp_cnt_out !== 1'b1) begin n_fails++; $display("FAIL drop_pulse got %0b exp 1", in_drp_cnt_out); end
    step();
    n_checks++;
    if (in_drp_cnt_out !== 1'b0) begin n_fails++; $display("FAIL drop_pulse_end got %0b exp 0", in_drp_cnt_out); end
  endtask

  task automatic test_drop_and_load();
    // drop_wait 2: drop fires on the second stalled cycle while B is offered.
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 16'd2;
    evt_data_in  = 32'h0000_0011;
    evt_vld_in   = 1'b1;
    step();
    evt_vld_in = 1'b0;
    step();
    evt_data_in = 32'h0000_0022;
    evt_vld_in  = 1'b1;
    step();
    evt_vld_in = 1'b0;
    n_checks++;
    if (pkt_vld_out !== 1'b1) begin n_fails++; $display("FAIL dropload_vld got %0b exp 1", pkt_vld_out); end
    n_checks++;
    if (pkt_data_out !== exp_pkt(32'h0000_0022)) begin
      n_fails++; $display("FAIL dropload_data got %h exp %h", pkt_data_out, exp_pkt(32'h0000_0022));
    end
    n_checks++;
    if (in_drp_cnt_out !== 1'b1) begin n_fails++; $display("FAIL dropload_drp got %0b exp 1", in_drp_cnt_out); end
    pkt_rdy_in = 1'b1;
    step();
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL dropload_done got %0b exp 0", pkt_vld_out); end
  endtask

  task automatic test_no_drop();
    int bad_vld;
    int bad_drp;
    int bad_rdy;
    bad_vld = 0;
    bad_drp = 0;
    bad_rdy = 0;
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 16'd0;
    evt_data_in  = 32'h0000_0001;
    evt_vld_in   = 1'b1;
    step();
    // Next event waits on the input the whole time.
    evt_data_in = 32'h0000_0003;
    for (int i = 0; i < 1000; i++) begin
      if (pkt_vld_out !== 1'b1) bad_vld++;
      if (in_drp_cnt_out !== 1'b0) bad_drp++;
      if (evt_rdy_out !== 1'b0) bad_rdy++;
      step();
    end
    n_checks++;
    if (bad_vld != 0) begin n_fails++; $display("FAIL nodrop_vld got %0d bad cycles exp 0", bad_vld); end
    n_checks++;
    if (bad_drp != 0) begin n_fails++; $display("FAIL nodrop_drp got %0d pulses exp 0", bad_drp); end
    n_checks++;
    if (bad_rdy != 0) begin n_fails++; $display("FAIL nodrop_rdy got %0d ready cycles exp 0", bad_rdy); end
    n_checks++;
    if (pkt_data_out !== exp_pkt(32'h0000_0001)) begin
      n_fails++; $display("FAIL nodrop_data got %h exp %h", pkt_data_out, exp_pkt(32'h0000_0001));
    end
    pkt_rdy_in = 1'b1;
    step();
    evt_vld_in = 1'b0;
    n_checks++;
    if (pkt_data_out !== exp_pkt(32'h0000_0003) || pkt_vld_out !== 1'b1) begin
      n_fails++; $display("FAIL nodrop_next got %h vld %0b exp %h vld 1", pkt_data_out, pkt_vld_out, exp_pkt(32'h0000_0003));
    end
    step();
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL nodrop_end got %0b exp 0", pkt_vld_out); end
  endtask

  task automatic test_back_to_back();
    pkt_rdy_in   = 1'b1;
    drop_wait_in = 16'd0;
    evt_keep_in  = 4'b1111;
    for (int k = 0; k < 100; k++) begin
      evt_data_in = 32'h0100_0000 + k;
      evt_last_in = ((k % 10) == 9);
      evt_vld_in  = 1'b1;
      if ((k % 10) == 9) exp_frm = exp_frm + 16'd1;
      step();
      n_checks++;
      if (pkt_vld_out !== 1'b1 || pkt_data_out !== exp_pkt(32'h0100_0000 + k)) begin
        n_fails++; $display("FAIL b2b[%0d] got %h vld %0b exp %h vld 1", k, pkt_data_out, pkt_vld_out, exp_pkt(32'h0100_0000 + k));
      end
    end
    evt_vld_in  = 1'b0;
    evt_last_in = 1'b0;
    step();
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL b2b_end got %0b exp 0", pkt_vld_out); end
    n_checks++;
    if (frm_cnt_out !== exp_frm) begin n_fails++; $display("FAIL b2b_frm got %0d exp %0d", frm_cnt_out, exp_frm); end
  endtask

  task automatic test_discard();
    pkt_rdy_in  = 1'b1;
    evt_data_in = 32'h0000_0777;
    evt_keep_in = 4'b0111;
    evt_last_in = 1'b1;
    evt_vld_in  = 1'b1;
    exp_frm     = exp_frm + 16'd1;
    step();
    evt_vld_in  = 1'b0;
    evt_last_in = 1'b0;
    evt_keep_in = 4'b1111;
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL discard_vld got %0b exp 0", pkt_vld_out); end
    n_checks++;
    if (in_drp_cnt_out !== 1'b1) begin n_fails++; $display("FAIL discard_drp got %0b exp 1", in_drp_cnt_out); end
    n_checks++;
    if (frm_cnt_out !== exp_frm) begin n_fails++; $display("FAIL discard_frm got %0d exp %0d", frm_cnt_out, exp_frm); end
    step();
    n_checks++;
    if (in_drp_cnt_out !== 1'b0) begin n_fails++; $display("FAIL discard_pulse_end got %0b exp 0", in_drp_cnt_out); end
  endtask

  task automatic test_reset_mid_stall();
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 16'd3;
    evt_data_in  = 32'h0000_0055;
    evt_vld_in   = 1'b1;
    step();
    evt_vld_in = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL rst_stall_vld got %0b exp 0", pkt_vld_out); end
    n_checks++;
    if (frm_cnt_out !== 16'h0) begin n_fails++; $display("FAIL rst_stall_frm got %0d exp 0", frm_cnt_out); end
    step();
    reset = 1'b0;
    // Two cycles with a stale counter would reach the drop point if it survived.
    step();
    step();
    n_checks++;
    if (in_drp_cnt_out !== 1'b0) begin n_fails++; $display("FAIL rst_stall_drp got %0b exp 0", in_drp_cnt_out); end
    n_checks++;
    if (evt_rdy_out !== 1'b1) begin n_fails++; $display("FAIL rst_stall_rdy got %0b exp 1", evt_rdy_out); end
    pkt_rdy_in  = 1'b1;
    evt_data_in = 32'h0000_0066;
    evt_vld_in  = 1'b1;
    step();
    evt_vld_in = 1'b0;
    n_checks++;
    if (pkt_vld_out !== 1'b1 || pkt_data_out !== exp_pkt(32'h0000_0066)) begin
      n_fails++; $display("FAIL rst_stall_next got %h vld %0b exp %h vld 1", pkt_data_out, pkt_vld_out, exp_pkt(32'h0000_0066));
    end
    step();
    n_checks++;
    if (pkt_vld_out !== 1'b0) begin n_fails++; $display("FAIL rst_stall_end got %0b exp 0", pkt_vld_out); end
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    exp_frm      = 16'h0;
    reset        = 1'b1;
    evt_data_in  = 32'h0;
    evt_keep_in  = 4'b1111;
    evt_last_in  = 1'b0;
    evt_vld_in   = 1'b0;
    key_base_in  = 32'h0;
    key_mask_in  = 32'h0;
    drop_wait_in = 16'd0;
    pkt_rdy_in   = 1'b1;

    test_reset();
    test_basic();
    test_drop();
    test_drop_and_load();
    test_no_drop();
    test_back_to_back();
    test_discard();
    test_reset_mid_stall();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
